// File: rtl/note_sequencer.sv
// Step-table note sequencer: plays (freq, dur) entries from an 8-deep table,
// drives an oscillator frequency word plus gate, with 1-cycle gaps between
// notes, optional looping and an end-of-sequence done pulse.
//
// state | meaning
// IDLE  | waiting for start; table writable; frequency_control holds pitch
// PLAY  | current step sounding for dur*TICK_DIV cycles
// GAP   | one silent cycle between steps, pitch held
// DONE  | one-cycle done pulse, then back to IDLE
module note_sequencer #(
    parameter int TICK_DIV  = 16,
    parameter int NUM_STEPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_freq,
    input  logic [7:0] wr_dur,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic [7:0] frequency_control,
    output logic       gate,
    output logic [2:0] step_index,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP, DONE} state_t;

    localparam logic [7:0] PRESCALE_LAST = 8'(TICK_DIV - 1);

    state_t     state;
    logic [7:0] prescaler;
    logic [7:0] ticks_left;
    logic [7:0] freq_tab [NUM_STEPS];
    logic [7:0] dur_tab  [NUM_STEPS];

    logic       wr_hits_0;
    logic [7:0] first_freq;
    logic [7:0] first_dur;
    logic [2:0] next_idx;
    logic       advance;
    logic [2:0] load_idx;

    // A write to entry 0 in the start cycle must be seen by that start.
    always_comb begin
        wr_hits_0  = wr_en && (wr_addr == 3'd0);
        first_freq = wr_hits_0 ? wr_freq : freq_tab[0];
        first_dur  = wr_hits_0 ? wr_dur  : dur_tab[0];
        next_idx   = step_index + 3'd1;
        advance    = (step_index != 3'd7) && (dur_tab[next_idx] != 8'd0);
        load_idx   = advance ? next_idx : 3'd0;
    end

    // Sequencer FSM, step table and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            prescaler         <= 8'd0;
            ticks_left        <= 8'd0;
            frequency_control <= 8'd0;
            gate              <= 1'b0;
            step_index        <= 3'd0;
            busy              <= 1'b0;
            done              <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                freq_tab[i] <= 8'd0;
                dur_tab[i]  <= 8'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        freq_tab[wr_addr] <= wr_freq;
                        dur_tab[wr_addr]  <= wr_dur;
                    end
                    if (start && !stop) begin
                        step_index <= 3'd0;
                        prescaler  <= 8'd0;
                        if (first_dur == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            gate  <= 1'b0;
                        end else begin
                            state      <= PLAY;
                            busy       <= 1'b1;
                            ticks_left <= first_dur;
                            gate       <= (first_freq != 8'd0);
                            // A rest keeps the previous pitch on the oscillator.
                            if (first_freq != 8'd0)
                                frequency_control <= first_freq;
                        end
                    end
                end
                PLAY: begin
                    if (stop) begin
                        state <= IDLE;
                        gate  <= 1'b0;
                        busy  <= 1'b0;
                    end else if (prescaler == PRESCALE_LAST) begin
                        prescaler <= 8'd0;
                        if (ticks_left == 8'd1) begin
                            state <= GAP;
                            gate  <= 1'b0;
                        end else begin
                            ticks_left <= ticks_left - 8'd1;
                        end
                    end else begin
                        prescaler <= prescaler + 8'd1;
                    end
                end
                GAP: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (advance || loop) begin
                        state      <= PLAY;
                        step_index <= load_idx;
                        prescaler  <= 8'd0;
                        ticks_left <= dur_tab[load_idx];
                        gate       <= (freq_tab[load_idx] != 8'd0);
                        if (freq_tab[load_idx] != 8'd0)
                            frequency_control <= freq_tab[load_idx];
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    gate  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer with TICK_DIV=4: directed scenarios
// plus randomized tables checked against a trace-building reference model.
module tb_note_sequencer;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_freq;
    logic [7:0] wr_dur;
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] frequency_control;
    logic       gate;
    logic [2:0] step_index;
    logic       busy;
    logic       done;

    note_sequencer #(.TICK_DIV(TICK_DIV), .NUM_STEPS(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .wr_en             (wr_en),
        .wr_addr           (wr_addr),
        .wr_freq           (wr_freq),
        .wr_dur            (wr_dur),
        .start             (start),
        .stop              (stop),
        .loop              (loop),
        .frequency_control (frequency_control),
        .gate              (gate),
        .step_index        (step_index),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [7:0]  m_freq [8];
    logic [7:0]  m_dur  [8];
    logic [7:0]  m_pitch;
    logic [2:0]  m_step;
    logic [13:0] exp_q [$];
    int          done_at;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [13:0] pk(input bit b, input bit d, input bit g,
                                       input logic [2:0] s, input logic [7:0] f);
        return {b, d, g, s, f};
    endfunction

    function automatic logic [15:0] outs();
        return {2'b00, busy, done, gate, step_index, frequency_control};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_freq[i] = 8'd0;
            m_dur[i]  = 8'd0;
        end
        m_pitch = 8'd0;
        m_step  = 3'd0;
    endtask

    task automatic write_entry(input int a, input logic [7:0] f, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_freq = f; wr_dur = d;
        tick();
        wr_en = 1'b0;
        m_freq[a] = f;
        m_dur[a]  = d;
    endtask

    // Expected per-cycle outputs from start onward, derived from the step rules.
    task automatic build_trace(input bit lp, input int max_len);
        int k;
        logic [7:0] f;
        exp_q.delete();
        f = m_pitch;
        k = 0;
        if (m_dur[0] == 8'd0) begin
            exp_q.push_back(pk(0, 1, 0, 3'd0, f));
            return;
        end
        while (exp_q.size() < max_len) begin
            if (m_freq[k] != 8'd0) f = m_freq[k];
            repeat (int'(m_dur[k]) * TICK_DIV)
                exp_q.push_back(pk(1, 0, m_freq[k] != 8'd0, 3'(k), f));
            exp_q.push_back(pk(1, 0, 0, 3'(k), f));
            if (k < 7 && m_dur[k+1] != 8'd0) k++;
            else if (lp) k = 0;
            else begin
                exp_q.push_back(pk(0, 1, 0, 3'(k), f));
                break;
            end
        end
    endtask

    // Start playback and compare every cycle; optional stop index, write noise,
    // and a write to entry 0 issued together with start.
    task automatic run_seq(input string tag, input bit lp, input int max_len,
                           input int stop_at, input bit noise,
                           input bit wr0, input logic [7:0] f0, input logic [7:0] d0);
        logic [13:0] e;
        int sa;
        loop = lp;
        if (wr0) begin
            wr_en = 1'b1; wr_addr = 3'd0; wr_freq = f0; wr_dur = d0;
            m_freq[0] = f0; m_dur[0] = d0;
        end
        build_trace(lp, max_len);
        sa = stop_at;
        if (sa >= exp_q.size()) sa = exp_q.size() - 1;
        done_at = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            e = exp_q[i];
            check_val(tag, outs(), {2'b00, e});
            if (done === 1'b1 && done_at < 0) done_at = i;
            if (noise) begin
                wr_en   = 1'($urandom_range(0, 1));
                wr_addr = ($urandom_range(0, 1) == 1) ? step_index : 3'($urandom_range(0, 7));
                wr_freq = 8'($urandom);
                wr_dur  = 8'($urandom);
            end
            if (i == sa) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                wr_en = 1'b0;
                break;
            end
            tick();
        end
        wr_en = 1'b0;
        e = exp_q[(sa >= 0) ? sa : exp_q.size() - 1];
        m_pitch = e[7:0];
        m_step  = e[10:8];
        check_val({tag, "_idle"}, outs(), {2'b00, pk(0, 0, 0, m_step, m_pitch)});
        tick();
        check_val({tag, "_idle2"}, outs(), {2'b00, pk(0, 0, 0, m_step, m_pitch)});
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_freq = 8'd0; wr_dur = 8'd0;
        start = 1'b0; stop = 1'b0; loop = 1'b0;
        model_clear();
        #12;
        check_val("reset_outs", outs(), 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_val("post_reset", outs(), 16'h0000);

        // basic two-note sequence then end marker
        write_entry(0, 8'd32, 8'd2);
        write_entry(1, 8'd64, 8'd1);
        write_entry(2, 8'd99, 8'd0);
        run_seq("seq_basic", 1'b0, 1000, -1, 1'b0, 1'b0, 8'd0, 8'd0);
        check_val("basic_idle_freq", {8'd0, frequency_control}, 16'd64);

        // looping wraps to step 0 without a done pulse, then stop
        run_seq("seq_loop", 1'b1, 17, 16, 1'b0, 1'b0, 8'd0, 8'd0);
        check_val("loop_stop_gate", {15'd0, gate}, 16'd0);
        loop = 1'b0;

        // stop and start together in IDLE: stop wins
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        check_val("stop_beats_start", outs(), {2'b00, pk(0, 0, 0, m_step, m_pitch)});

        // full eight-step table, one tick each
        for (int i = 0; i < 8; i++) write_entry(i, 8'(10 + i * 7), 8'd1);
        run_seq("seq_full", 1'b0, 1000, -1, 1'b0, 1'b0, 8'd0, 8'd0);
        check_val("full_done_cycle", 16'(done_at), 16'd40);

        // rest in the middle keeps the previous pitch
        write_entry(0, 8'd50, 8'd1);
        write_entry(1, 8'd0, 8'd1);
        write_entry(2, 8'd70, 8'd1);
        write_entry(3, 8'd5, 8'd0);
        run_seq("seq_rest", 1'b0, 1000, -1, 1'b0, 1'b0, 8'd0, 8'd0);

        // writes during playback are ignored
        write_entry(0, 8'd21, 8'd2);
        write_entry(1, 8'd42, 8'd2);
        run_seq("seq_wr_play", 1'b0, 1000, -1, 1'b1, 1'b0, 8'd0, 8'd0);

        // empty first step: immediate done, busy never set
        write_entry(0, 8'd33, 8'd0);
        run_seq("seq_empty", 1'b0, 1000, -1, 1'b0, 1'b0, 8'd0, 8'd0);

        // asynchronous reset mid-step
        write_entry(0, 8'd80, 8'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_val("pre_reset_busy", {15'd0, busy}, 16'd1);
        #1 reset = 1'b1;
        #1;
        check_val("async_reset", outs(), 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        run_seq("seq_after_reset", 1'b0, 1000, -1, 1'b0, 1'b0, 8'd0, 8'd0);

        // randomized tables, optional stop, write noise, write-with-start
        for (int it = 0; it < 30; it++) begin
            int nv;
            bit w0;
            nv = $urandom_range(0, 8);
            for (int i = 0; i < 8; i++) begin
                logic [7:0] f;
                logic [7:0] d;
                f = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                if (i < nv) d = 8'($urandom_range(1, 3));
                else if (i == nv) d = 8'd0;
                else d = 8'($urandom_range(0, 3));
                write_entry(i, f, d);
            end
            w0 = 1'($urandom_range(0, 1));
            run_seq("rand", 1'b0, 1000,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 100)) : -1,
                    1'b1, w0,
                    8'($urandom_range(0, 255)),
                    (nv == 0) ? 8'd0 : 8'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
